// File: rtl/switch_debouncer.sv
// Switch debouncer: 2-flop synchronizer plus a per-bit stability counter.
// Define SWITCH_DEBOUNCER_EDGE_EN to build the registered rise/fall pulse outputs.
module switch_debouncer #(
  parameter int unsigned N             = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] switch,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]     s1_q, s2_q;
  logic [N-1:0]     switch_q, switch_d;
  logic [N-1:0]     upd;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  // A bit flips only after STABLE_CYCLES consecutive disagreeing samples; one agreeing
  // sample throws the whole count away.
  always_comb begin
    upd = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != switch_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          upd[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    switch_d = switch_q ^ upd;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      switch_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      switch_q <= switch_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switch = switch_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [N-1:0] rise_q, fall_q;

  // On an update the new level equals s2, so s2 selects the pulse direction.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & s2_q;
      fall_q <= upd & ~s2_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer against a sliding-window model.
// Pulse expectations follow SWITCH_DEBOUNCER_EDGE_EN the same way the design does.
module tb_switch_debouncer;

  localparam int unsigned N = 4;
  localparam int unsigned S = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_rst;
  logic [N-1:0] raw;
  logic [N-1:0] switch, rise, fall;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  switch_debouncer #(
    .N             (N),
    .STABLE_CYCLES (S)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .raw    (raw),
    .switch (switch),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;

  // Model: the value seen at an edge is raw delayed two edges; a bit takes the new level
  // when the last S seen values all disagree with its current output.
  logic [N-1:0] m_p1, m_p2, m_sw, m_rise, m_fall;
  logic [N-1:0] hist [$];

  function automatic void model_edge();
    bit all_diff;
    if (!n_rst) begin
      m_p1 = '0; m_p2 = '0; m_sw = '0; m_rise = '0; m_fall = '0;
      hist.delete();
    end else begin
      hist.push_back(m_p2);
      if (hist.size() > S) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (hist.size() == S) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < hist.size(); j++) begin
            if (hist[j][i] == m_sw[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_sw[i] = ~m_sw[i];
            if (m_sw[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end
      end
      m_p2 = m_p1;
      m_p1 = raw;
    end
  endfunction

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_switch", switch, m_sw);
    chk("model_rise", rise, EdgeEn ? m_rise : '0);
    chk("model_fall", fall, EdgeEn ? m_fall : '0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    raw   = '0;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  int unsigned n_rise1, n_rise3, n_fall3, n_pulse;

  initial begin
    // Reset held with all switches high.
    raw   = 4'hF;
    n_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_switch", switch, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
    end
    n_rst = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("rel_before_edge5", switch, 4'h0);
    tick();
    chk("rel_switch_edge5", switch, 4'hF);
    chk("rel_rise_edge5", rise, EdgeEn ? 4'hF : 4'h0);
    tick();
    chk("rel_rise_one_cycle", rise, 4'h0);

    // Clean press on bit 0.
    do_reset();
    raw = 4'h1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("press_wait", switch, 4'h0);
    end
    tick();
    chk("press_switch", switch, 4'h1);
    chk("press_rise", rise, EdgeEn ? 4'h1 : 4'h0);
    chk("press_fall", fall, 4'h0);
    tick();
    chk("press_rise_end", rise, 4'h0);

    // Bounce on bit 1: 1,0,1,0 then hold 1.
    n_rise1 = 0;
    for (int k = 0; k < 4; k++) begin
      raw = (k % 2 == 0) ? 4'h3 : 4'h1;
      tick();
      n_rise1 += rise[1];
      chk("bounce_toggle", switch & 4'h2, 4'h0);
    end
    raw = 4'h3;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_rise1 += rise[1];
      chk("bounce_hold", switch & 4'h2, 4'h0);
    end
    tick();
    n_rise1 += rise[1];
    chk("bounce_switch", switch, 4'h3);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_rise1 += rise[1];
    end
    chk("bounce_rise_count", 4'(n_rise1), EdgeEn ? 4'h1 : 4'h0);

    // Simultaneous bits; bit 3 drops after two cycles.
    do_reset();
    n_rise3 = 0;
    n_fall3 = 0;
    raw = 4'hA;
    tick();
    tick();
    raw = 4'h2;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_rise3 += rise[3];
      n_fall3 += fall[3];
      chk("simul_wait", switch, 4'h0);
    end
    tick();
    chk("simul_switch", switch, 4'h2);
    chk("simul_rise", rise, EdgeEn ? 4'h2 : 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_rise3 += rise[3];
      n_fall3 += fall[3];
    end
    chk("simul_bit3_pulses", 4'(n_rise3 + n_fall3), 4'h0);

    // Release.
    do_reset();
    raw = 4'h1;
    for (int k = 0; k < 7; k++) tick();
    raw = 4'h0;
    for (int k = 0; k < 5; k++) tick();
    chk("release_wait", switch, 4'h1);
    tick();
    chk("release_switch", switch, 4'h0);
    chk("release_fall", fall, EdgeEn ? 4'h1 : 4'h0);
    tick();
    chk("release_fall_end", fall, 4'h0);

    // Release interrupted by reset after edge 3.
    raw = 4'h1;
    for (int k = 0; k < 7; k++) tick();
    raw = 4'h0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_before", switch, 4'h1);
    n_rst = 1'b0;
    #1;
    chk("midrst_async_switch", switch, 4'h0);
    chk("midrst_async_rise", rise, 4'h0);
    chk("midrst_async_fall", fall, 4'h0);
    tick();
    n_rst   = 1'b1;
    n_pulse = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_pulse += $countones(rise) + $countones(fall);
    end
    chk("midrst_no_pulse", 4'(n_pulse), 4'h0);
    chk("midrst_switch", switch, 4'h0);

    // Random traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
      end
      n_rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the four raw board switches before they reach the CPU's `switch` input, which is sampled directly into the accumulator on an LED-ON instruction. Each bit passes through a two-flop synchronizer and a per-bit stability counter, so the CPU only sees a level that has held steady for a programmable number of cycles. Optional registered rise/fall pulses are provided for later instructions or peripherals that react to switch edges.

## Interface

Parameters:
- `N`, default 4: number of switch bits.
- `STABLE_CYCLES`, default 4: number of consecutive synchronized samples that must differ from the current output before the output changes. Legal range is 2 to 2^16. Simulation uses the default; board builds override it, e.g. 250000 at 25 MHz for 10 ms.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: counter width. Derived; do not override.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `raw`, input, N: asynchronous switch pins.
- `switch`, output, N: debounced level, registered. Connects to the CPU `switch` input.
- `rise`, output, N: one-cycle pulse when a `switch` bit goes 0→1.
- `fall`, output, N: one-cycle pulse when a `switch` bit goes 1→0.

## Operation

- **Synchronizer:** `s1 <= raw`, `s2 <= s1` on every edge.
- **Per bit i, on each edge, there are two states:**
  - **STABLE** (`s2[i] == switch[i]`):
    - `cnt[i] <= 0`.
  - **COUNTING** (`s2[i] != switch[i]`):
    - If `cnt[i] == STABLE_CYCLES-1`: `switch[i] <= s2[i]`, `cnt[i] <= 0`, and pulse `rise[i]` or `fall[i]` according to the new value.
    - Otherwise: `cnt[i] <= cnt[i]+1`.
- **Glitch handling:** any single sample with `s2[i] == switch[i]` returns the bit to STABLE and clears its count. There is no partial credit.
- **Bit independence:** bits are fully independent. Simultaneous changes on several bits are each debounced on their own counters.
- **Counter range:** `cnt[i]` never exceeds `STABLE_CYCLES-1`. No wrap-around is possible.
- **Pulse timing:** `rise` and `fall` are registered outputs. They are high for exactly the one cycle following the edge that updates `switch`, and never both high for the same bit.

## Timing

- **Reset values:** `s1`, `s2`, `switch`, all `cnt`, `rise` and `fall` are 0 while `n_rst` is low. They clear immediately and asynchronously, without waiting for a clock.
- **Latency:** with `raw[i]` changed before edge 0 and held, `switch[i]` updates at edge `STABLE_CYCLES+1`. That is 2 synchronizer edges plus `STABLE_CYCLES-1` counting edges. The matching pulse is high during the cycle after that edge.
- **High at reset release:** a bit held high through reset release reaches `switch` on edge `STABLE_CYCLES+1` after the first post-reset edge and produces a `rise` pulse.
- **Reset mid-count:** asserting reset while a bit is counting discards the count. After release, debouncing restarts from 0.
- **Minimum change interval:** a new level must be held for at least `STABLE_CYCLES` cycles after synchronization to be accepted. Toggling every cycle never changes `switch`.
- **Downstream use:** `switch` changes only on `clk` edges and is glitch-free, so the CPU may sample it on any cycle.

## Configuration

- **Macro `SWITCH_DEBOUNCER_EDGE_EN`:**
  - **Defined:** the `rise`/`fall` registers and pulse logic are built as described above.
  - **Not defined:** `rise` and `fall` are tied to constant 0, and the edge registers are not instantiated. `switch` behaviour and timing are identical in both cases.

## Test plan

- **Reset:** hold `n_rst` low with `raw=4'hF` and toggle clocks.
  - Required: `switch=0`, `rise=0`, `fall=0` throughout.
  - Then release reset: `switch=4'hF` at edge 5 (default `STABLE_CYCLES=4`), with `rise=4'hF` for one cycle.
- **Clean press:** `raw[0]` 0→1 before edge 0 and held.
  - Required: `switch=4'b0001` first visible after edge 5, `rise=4'b0001` for exactly one cycle, `fall=0`.
- **Bounce:** `raw[1]` toggles 1,0,1,0 on consecutive cycles, then holds at 1.
  - Required: `switch[1]` stays 0 during the toggling and becomes 1 exactly 5 edges after the final transition.
  - Required: exactly one `rise[1]` pulse.
- **Simultaneous bits:** `raw` goes 0→`4'hA` at one time, then bit 3 alone returns to 0 two cycles later.
  - Required: `switch` becomes `4'h2` at edge 5. Bit 3 never changes and no pulse appears on it.
- **Release and reset mid-count:**
  - With `switch=4'h1`, drop `raw` to 0. Required: `fall[0]` pulse and `switch=0` at edge 5.
  - Repeat, but assert `n_rst` at edge 3. Required: immediate clear to 0, and no pulse after release.
- **Macro undefined:** rerun the clean-press scenario.
  - Required: `switch` timing unchanged, and `rise` and `fall` stay 0 throughout.
